alu_op_sequencer: RTL

//  Driving/capturing end of the 32-bit ALU interface (A, B, ALU_OP in; F, OF, ZF out).

---
 rtl/alu_op_sequencer_pkg.sv | 36 +++
 rtl/alu_op_sequencer_if.sv | 36 +++
 rtl/alu_op_sequencer_ref_model.sv | 51 +++++
 rtl/alu_op_sequencer.sv | 174 +++++++++++++++++
 4 files changed

// File: rtl/alu_op_sequencer_pkg.sv
// alu_seq_pkg: shared types and helpers for the ALU operand sequencer.
//   state_t  : sequencer FSM states
//   alu_op_t : 3-bit ALU operation encoding
//   cnt_w()  : counter width for a terminal count (at least 1 bit)
// Optional feature macro used elsewhere in this slice: ALU_SELFCHECK_EN
package alu_seq_pkg;

  localparam int unsigned BYTE_W = 8;
  localparam int unsigned OP_W   = 3;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    LOAD_A  = 3'd1,
    LOAD_B  = 3'd2,
    WAIT_OP = 3'd3,
    EXEC    = 3'd4,
    CAPTURE = 3'd5
  } state_t;

  typedef enum logic [OP_W-1:0] {
    OP_AND = 3'b000,
    OP_OR  = 3'b001,
    OP_XOR = 3'b010,
    OP_NOR = 3'b011,
    OP_ADD = 3'b100,
    OP_SUB = 3'b101,
    OP_SLT = 3'b110,
    OP_SLL = 3'b111
  } alu_op_t;

  // Bits needed to hold values 0..n-1, never less than one.
  function automatic int unsigned cnt_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/alu_op_sequencer_if.sv
// alu_seq_if: byte-stream input, start/op control, ALU drive/capture and result display.
//   slave  : the sequencer side (consumes bytes, drives ALU operands, owns results)
//   master : the environment side (byte source, buttons, combinational ALU, display)
interface alu_seq_if #(
  parameter int unsigned DW = 32
);
  import alu_seq_pkg::*;

  logic [BYTE_W-1:0] in_data;
  logic              in_valid;
  logic              in_ready;
  logic [OP_W-1:0]   op_in;
  logic              start;
  logic [DW-1:0]     alu_a;
  logic [DW-1:0]     alu_b;
  logic [OP_W-1:0]   alu_op;
  logic [DW-1:0]     alu_f;
  logic              alu_of;
  logic              alu_zf;
  logic [DW-1:0]     res_f;
  logic              res_of;
  logic              res_zf;
  logic              done;
  logic              busy;

  modport slave (
    input  in_data, in_valid, op_in, start, alu_f, alu_of, alu_zf,
    output in_ready, alu_a, alu_b, alu_op, res_f, res_of, res_zf, done, busy
  );

  modport master (
    output in_data, in_valid, op_in, start, alu_f, alu_of, alu_zf,
    input  in_ready, alu_a, alu_b, alu_op, res_f, res_of, res_zf, done, busy
  );

endinterface

// File: rtl/alu_op_sequencer_ref_model.sv
// alu_ref_model: combinational expected ALU result used for result self-checking.
//   i_a, i_b   : operands
//   i_op       : operation code (alu_op_t encoding)
//   o_f        : expected result
//   o_of       : expected overflow (meaningful only when o_of_vld)
//   o_of_vld   : overflow is defined for this op (ADD/SUB)
//   o_zf       : expected zero flag
module alu_ref_model
  import alu_seq_pkg::*;
#(
  parameter int unsigned DW = 32
) (
  input  logic [DW-1:0]   i_a,
  input  logic [DW-1:0]   i_b,
  input  logic [OP_W-1:0] i_op,
  output logic [DW-1:0]   o_f,
  output logic            o_of,
  output logic            o_of_vld,
  output logic            o_zf
);

  localparam int unsigned SHW = cnt_w(DW);

  // Reference function: result, then signed overflow for ADD/SUB only.
  always_comb begin
    o_f      = '0;
    o_of     = 1'b0;
    o_of_vld = 1'b0;
    case (alu_op_t'(i_op))
      OP_AND: o_f = i_a & i_b;
      OP_OR:  o_f = i_a | i_b;
      OP_XOR: o_f = i_a ^ i_b;
      OP_NOR: o_f = ~(i_a | i_b);
      OP_ADD: begin
        o_f      = i_a + i_b;
        o_of_vld = 1'b1;
        o_of     = (i_a[DW-1] == i_b[DW-1]) && (o_f[DW-1] != i_a[DW-1]);
      end
      OP_SUB: begin
        o_f      = i_a - i_b;
        o_of_vld = 1'b1;
        o_of     = (i_a[DW-1] != i_b[DW-1]) && (o_f[DW-1] != i_a[DW-1]);
      end
      OP_SLT: o_f = DW'($signed(i_a) < $signed(i_b));
      OP_SLL: o_f = i_b << i_a[SHW-1:0];
      default: o_f = '0;
    endcase
    o_zf = (o_f == '0);
  end

endmodule

// File: rtl/alu_op_sequencer.sv
// alu_op_sequencer: assembles A/B from an LSB-first byte stream, drives the
// combinational ALU, waits SETTLE cycles, captures F/OF/ZF and holds them.
//   clk, rst   : clock, synchronous active-high reset
//   bus        : alu_seq_if.slave (byte stream, start/op, ALU drive/capture, results)
//   mismatch   : (ALU_SELFCHECK_EN only) captured result disagrees with reference
// Optional feature macro: ALU_SELFCHECK_EN
module alu_op_sequencer
  import alu_seq_pkg::*;
#(
  parameter int unsigned DW     = 32,
  parameter int unsigned SETTLE = 1
) (
  input  logic     clk,
  input  logic     rst,
  alu_seq_if.slave bus
`ifdef ALU_SELFCHECK_EN
  ,
  output logic     mismatch
`endif
);

  localparam int unsigned NB  = DW / BYTE_W;
  localparam int unsigned BCW = cnt_w(NB);
  localparam int unsigned SCW = cnt_w(SETTLE + 1);

  state_t             r_state;
  state_t             w_state_nxt;
  logic [BCW-1:0]     r_byte_cnt;
  logic [SCW-1:0]     r_settle;
  logic [DW-1:0]      r_alu_a;
  logic [DW-1:0]      r_alu_b;
  logic [OP_W-1:0]    r_alu_op;
  logic [DW-1:0]      r_res_f;
  logic               r_res_of;
  logic               r_res_zf;
  logic               r_done;
  logic               r_busy;
  logic               r_in_ready;

  logic               w_hs;
  logic               w_last_byte;
  logic               w_acc_a;
  logic               w_acc_b;
  logic               w_start_ok;
  logic               w_capture;

  assign w_hs        = bus.in_valid & r_in_ready;
  assign w_last_byte = (r_byte_cnt == BCW'(NB - 1));

  // State register.
  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_state_nxt;
  end

  // Next state and datapath strobes.
  always_comb begin
    w_state_nxt = r_state;
    w_acc_a     = 1'b0;
    w_acc_b     = 1'b0;
    w_start_ok  = 1'b0;
    w_capture   = 1'b0;
    case (r_state)
      // IDLE already consumes the first byte of A.
      IDLE, LOAD_A: begin
        if (w_hs) begin
          w_acc_a     = 1'b1;
          w_state_nxt = w_last_byte ? LOAD_B : LOAD_A;
        end
      end
      LOAD_B: begin
        if (w_hs) begin
          w_acc_b     = 1'b1;
          w_state_nxt = w_last_byte ? WAIT_OP : LOAD_B;
        end
      end
      WAIT_OP: begin
        if (bus.start) begin
          w_start_ok  = 1'b1;
          w_state_nxt = EXEC;
        end
      end
      EXEC: begin
        if (r_settle <= SCW'(1)) w_state_nxt = CAPTURE;
      end
      CAPTURE: begin
        w_capture   = 1'b1;
        w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // Operand assembly, op latch, settle count, result capture, status flags.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_byte_cnt <= '0;
      r_settle   <= '0;
      r_alu_a    <= '0;
      r_alu_b    <= '0;
      r_alu_op   <= '0;
      r_res_f    <= '0;
      r_res_of   <= 1'b0;
      r_res_zf   <= 1'b0;
      r_done     <= 1'b0;
      r_busy     <= 1'b0;
      r_in_ready <= 1'b1;
    end else begin
      if (w_acc_a) r_alu_a[{r_byte_cnt, 3'b000} +: BYTE_W] <= bus.in_data;
      if (w_acc_b) r_alu_b[{r_byte_cnt, 3'b000} +: BYTE_W] <= bus.in_data;
      if (w_acc_a || w_acc_b) r_byte_cnt <= w_last_byte ? '0 : r_byte_cnt + BCW'(1);

      if (w_start_ok) begin
        r_alu_op <= bus.op_in;
        r_settle <= SCW'(SETTLE);
      end else if (r_state == EXEC && r_settle != '0) begin
        r_settle <= r_settle - SCW'(1);
      end

      if (w_capture) begin
        r_res_f  <= bus.alu_f;
        r_res_of <= bus.alu_of;
        r_res_zf <= bus.alu_zf;
      end

      r_done     <= w_capture;
      r_busy     <= !(w_state_nxt == IDLE || w_state_nxt == WAIT_OP);
      r_in_ready <= (w_state_nxt == IDLE || w_state_nxt == LOAD_A || w_state_nxt == LOAD_B);
    end
  end

  assign bus.in_ready = r_in_ready;
  assign bus.alu_a    = r_alu_a;
  assign bus.alu_b    = r_alu_b;
  assign bus.alu_op   = r_alu_op;
  assign bus.res_f    = r_res_f;
  assign bus.res_of   = r_res_of;
  assign bus.res_zf   = r_res_zf;
  assign bus.done     = r_done;
  assign bus.busy     = r_busy;

`ifdef ALU_SELFCHECK_EN
  logic [DW-1:0] w_ref_f;
  logic          w_ref_of;
  logic          w_ref_of_vld;
  logic          w_ref_zf;
  logic          w_ref_mis;
  logic          r_mismatch;

  alu_ref_model #(.DW(DW)) u_ref (
    .i_a      (r_alu_a),
    .i_b      (r_alu_b),
    .i_op     (r_alu_op),
    .o_f      (w_ref_f),
    .o_of     (w_ref_of),
    .o_of_vld (w_ref_of_vld),
    .o_zf     (w_ref_zf)
  );

  // OF is undefined outside ADD/SUB, so it only participates there.
  assign w_ref_mis = (bus.alu_f != w_ref_f) || (bus.alu_zf != w_ref_zf) ||
                     (w_ref_of_vld && (bus.alu_of != w_ref_of));

  // Sticky until the next accepted start.
  always_ff @(posedge clk) begin
    if (rst)             r_mismatch <= 1'b0;
    else if (w_start_ok) r_mismatch <= 1'b0;
    else if (w_capture)  r_mismatch <= w_ref_mis;
  end

  assign mismatch = r_mismatch;
`endif

endmodule
